// File: rtl/softex_pkg.sv
// Shared constants and types for the SoftEx TCDM responder.
// Word geometry, default base address and the out-of-range read pattern.
package softex_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BE_W   = WORD_W / BYTE_W;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ERR_W  = 16;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h1000_0000;
    localparam logic [WORD_W-1:0] OOR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

    // 33-bit compare so BASE + 8*DEPTH cannot wrap.
    function automatic logic addr_in_range(
        input logic [ADDR_W-1:0] add,
        input logic [ADDR_W-1:0] base,
        input int unsigned       depth
    );
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        logic [ADDR_W:0] a;
        lo = {1'b0, base};
        hi = lo + (ADDR_W+1)'(depth) * (ADDR_W+1)'(BE_W);
        a  = {1'b0, add};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/softex_tcdm_resp_slot.sv
// Per-port response register: loads on grant, holds under back-pressure,
// clears on acceptance unless a new grant reloads it in the same cycle.
module softex_tcdm_resp_slot
    import softex_pkg::*;
#(
    parameter int unsigned ID_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [ID_W-1:0]   load_id,
    input  logic              r_ready,
    output logic              r_valid,
    output logic [WORD_W-1:0] r_data,
    output logic [ID_W-1:0]   r_id,
    output logic              busy
);

    slot_state_e state_q;
    slot_state_e state_d;
    logic [WORD_W-1:0] data_q;
    logic [ID_W-1:0]   id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (load) state_d = SLOT_FULL;
            end
            SLOT_FULL: begin
                if (load)         state_d = SLOT_FULL;
                else if (r_ready) state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        r_valid = (state_q == SLOT_FULL);
        busy    = r_valid & ~r_ready;
        r_data  = data_q;
        r_id    = id_q;
    end

    // Load is only possible when not busy, so held data is never overwritten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            id_q   <= '0;
        end else if (load) begin
            data_q <= load_data;
            id_q   <= load_id;
        end else if ((state_q == SLOT_FULL) && r_ready) begin
            data_q <= '0;
            id_q   <= '0;
        end
    end

endmodule

// File: rtl/softex_tcdm_responder.sv
// Multi-port TCDM slave model: shared 64-bit word memory, one response
// slot per port, out-of-range error counter.
module softex_tcdm_responder
    import softex_pkg::*;
#(
    parameter int unsigned       MP        = 4,
    parameter int unsigned       DEPTH     = 2048,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned       ID_W      = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [MP-1:0]                tcdm_req_i,
    output logic [MP-1:0]                tcdm_gnt_o,
    input  logic [MP-1:0][ADDR_W-1:0]    tcdm_add_i,
    input  logic [MP-1:0]                tcdm_wen_i,
    input  logic [MP-1:0][BE_W-1:0]      tcdm_be_i,
    input  logic [MP-1:0][WORD_W-1:0]    tcdm_data_i,
    input  logic [MP-1:0][ID_W-1:0]      tcdm_id_i,
    input  logic [MP-1:0]                tcdm_r_ready_i,
    output logic [MP-1:0]                tcdm_r_valid_o,
    output logic [MP-1:0][WORD_W-1:0]    tcdm_r_data_o,
    output logic [MP-1:0][ID_W-1:0]      tcdm_r_id_o,
    input  logic [MP-1:0]                stall_i,
    output logic [ERR_W-1:0]             err_cnt_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [MP-1:0]             busy;
    logic [MP-1:0]             hs;
    logic [MP-1:0]             in_rng;
    logic [MP-1:0][IDX_W-1:0]  idx;
    logic [MP-1:0][WORD_W-1:0] rsp_data;
    logic [ERR_W-1:0]          err_q;
    logic [ERR_W-1:0]          err_d;

    assign tcdm_gnt_o = tcdm_req_i & ~stall_i & ~busy;
    assign hs         = tcdm_req_i & tcdm_gnt_o;
    assign err_cnt_o  = err_q;

    always_comb begin : addr_dec
        logic [ADDR_W-1:0] off;
        for (int p = 0; p < MP; p++) begin
            off       = tcdm_add_i[p] - BASE_ADDR;
            idx[p]    = off[IDX_W+2:3];
            in_rng[p] = addr_in_range(tcdm_add_i[p], BASE_ADDR, DEPTH);
            if (!tcdm_wen_i[p]) begin
                rsp_data[p] = '0;
            end else if (in_rng[p]) begin
                rsp_data[p] = mem[idx[p]];
            end else begin
                rsp_data[p] = OOR_PATTERN;
            end
        end
    end

    // Ascending port order: the highest enabled port wins each byte.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (hs[p] && !tcdm_wen_i[p] && in_rng[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (tcdm_be_i[p][b]) begin
                        mem[idx[p]][b*BYTE_W +: BYTE_W] <=
                            tcdm_data_i[p][b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    always_comb begin : err_upd
        logic [ERR_W:0] inc;
        logic [ERR_W:0] sum;
        inc = '0;
        for (int p = 0; p < MP; p++) begin
            if (hs[p] && !in_rng[p]) inc = inc + 1'b1;
        end
        sum   = {1'b0, err_q} + inc;
        err_d = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    for (genvar p = 0; p < MP; p++) begin : g_slot
        softex_tcdm_resp_slot #(
            .ID_W (ID_W)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .load      (hs[p]),
            .load_data (rsp_data[p]),
            .load_id   (tcdm_id_i[p]),
            .r_ready   (tcdm_r_ready_i[p]),
            .r_valid   (tcdm_r_valid_o[p]),
            .r_data    (tcdm_r_data_o[p]),
            .r_id      (tcdm_r_id_o[p]),
            .busy      (busy[p])
        );
    end

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Directed bench for softex_tcdm_responder with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs checked there too.
module tb_softex_tcdm_responder;

    localparam int unsigned MP    = 4;
    localparam int unsigned DEPTH = 2048;
    localparam int unsigned ID_W  = 8;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] OOR_HI = BASE + 32'(8 * DEPTH);
    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DA = 64'hAAAA_5555_AAAA_5555;
    localparam logic [63:0] DB = 64'hBBBB_CCCC_DDDD_EEEE;
    localparam logic [63:0] DBEEF = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic [MP-1:0]            req, gnt, wen, r_ready, r_valid, stall;
    logic [MP-1:0][31:0]      add;
    logic [MP-1:0][7:0]       be;
    logic [MP-1:0][63:0]      wdata, r_data;
    logic [MP-1:0][ID_W-1:0]  id, r_id;
    logic [15:0]              err_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    softex_tcdm_responder #(
        .MP(MP), .DEPTH(DEPTH), .BASE_ADDR(BASE), .ID_W(ID_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_be_i      (be),
        .tcdm_data_i    (wdata),
        .tcdm_id_i      (id),
        .tcdm_r_ready_i (r_ready),
        .tcdm_r_valid_o (r_valid),
        .tcdm_r_data_o  (r_data),
        .tcdm_r_id_o    (r_id),
        .stall_i        (stall),
        .err_cnt_o      (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        req = '0;
    endtask

    task automatic rd(input int p, input logic [31:0] a,
                      input logic [7:0] i);
        req[p] = 1'b1; wen[p] = 1'b1; add[p] = a;
        be[p] = '0; wdata[p] = '0; id[p] = i;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [7:0] b,
                      input logic [63:0] d, input logic [7:0] i);
        req[p] = 1'b1; wen[p] = 1'b0; add[p] = a;
        be[p] = b; wdata[p] = d; id[p] = i;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; req = '0; wen = '1; add = '0; be = '0;
        wdata = '0; id = '0; r_ready = '1; stall = '0;
        #12;
        chk("rst_rvalid", 64'(r_valid), 64'h0);
        chk("rst_rdata0", r_data[0], 64'h0);
        chk("rst_rid3", 64'(r_id[3]), 64'h0);
        chk("rst_err", 64'(err_cnt), 64'h0);
        chk("rst_gnt", 64'(gnt), 64'h0);
        step();
        rst_ni = 1'b1;

        // basic write then read on another port
        wr(0, BASE + 8, 8'hFF, D1, 8'h11);
        #1 chk("wr_gnt0", 64'(gnt[0]), 64'h1);
        step(); idle_all();
        chk("wr_rvalid0", 64'(r_valid[0]), 64'h1);
        chk("wr_rid0", 64'(r_id[0]), 64'h11);
        chk("wr_rdata0", r_data[0], 64'h0);
        rd(2, BASE + 8 + 3, 8'h22);
        step(); idle_all();
        chk("wr_rvalid0_clr", 64'(r_valid[0]), 64'h0);
        chk("rd_rvalid2", 64'(r_valid[2]), 64'h1);
        chk("rd_rdata2", r_data[2], D1);
        chk("rd_rid2", 64'(r_id[2]), 64'h22);
        step();
        chk("rd_rvalid2_clr", 64'(r_valid[2]), 64'h0);

        // partial write and be=0 write
        wr(1, BASE, 8'hFF, 64'h0, 8'h01); step();
        wr(1, BASE, 8'h0F, ONES, 8'h02); step();
        wr(1, BASE, 8'h00, ONES, 8'h03); step();
        chk("be0_rvalid1", 64'(r_valid[1]), 64'h1);
        chk("be0_rid1", 64'(r_id[1]), 64'h03);
        rd(1, BASE, 8'h04); step(); idle_all();
        chk("partial_rdata1", r_data[1], 64'h0000_0000_FFFF_FFFF);

        // same-word write collision: port 3 wins
        wr(0, BASE + 16, 8'hFF, DA, 8'h05);
        wr(3, BASE + 16, 8'hFF, DB, 8'h06);
        step(); idle_all();
        rd(1, BASE + 16, 8'h07); step(); idle_all();
        chk("collide_rdata1", r_data[1], DB);

        // read-before-write across ports
        wr(0, BASE + 24, 8'hFF, 64'h1111, 8'h08); step();
        wr(0, BASE + 24, 8'hFF, 64'h2222, 8'h09);
        rd(2, BASE + 24, 8'h0A);
        step(); idle_all();
        chk("rbw_old", r_data[2], 64'h1111);
        rd(2, BASE + 24, 8'h0B); step(); idle_all();
        chk("rbw_new", r_data[2], 64'h2222);

        // back-pressure on port 1 while port 0 streams
        r_ready[1] = 1'b0;
        rd(1, BASE + 8, 8'h31);
        rd(0, BASE, 8'h40);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("bp_rid0", 64'(r_id[0]), 64'h40 + 64'(k));
            chk("bp_rvalid1", 64'(r_valid[1]), 64'h1);
            chk("bp_rdata1", r_data[1], D1);
            chk("bp_rid1", 64'(r_id[1]), 64'h31);
            rd(0, BASE, 8'h41 + 8'(k));
            #1;
            chk("bp_gnt1", 64'(gnt[1]), 64'h0);
            chk("bp_gnt0", 64'(gnt[0]), 64'h1);
            step();
        end
        r_ready[1] = 1'b1;
        rd(1, BASE + 16, 8'h32);
        #1 chk("b2b_gnt1", 64'(gnt[1]), 64'h1);
        step(); idle_all();
        chk("b2b_rvalid1", 64'(r_valid[1]), 64'h1);
        chk("b2b_rid1", 64'(r_id[1]), 64'h32);
        chk("b2b_rdata1", r_data[1], DB);
        step();
        chk("b2b_clr1", 64'(r_valid[1]), 64'h0);

        // stall isolates one port
        stall[2] = 1'b1;
        rd(2, BASE, 8'h50);
        rd(3, BASE, 8'h51);
        #1;
        chk("stall_gnt2", 64'(gnt[2]), 64'h0);
        chk("stall_gnt3", 64'(gnt[3]), 64'h1);
        step(); idle_all();
        stall = '0;
        chk("stall_rvalid2", 64'(r_valid[2]), 64'h0);
        chk("stall_rvalid3", 64'(r_valid[3]), 64'h1);

        // out-of-range handling and saturation
        rd(0, OOR_HI, 8'h60); step(); idle_all();
        chk("oor_rdata0", r_data[0], DBEEF);
        chk("oor_err1", 64'(err_cnt), 64'd1);
        wr(0, OOR_HI + 8, 8'hFF, ONES, 8'h61); step(); idle_all();
        chk("oor_wr_rvalid", 64'(r_valid[0]), 64'h1);
        chk("oor_err2", 64'(err_cnt), 64'd2);
        rd(0, BASE + 8, 8'h62); step(); idle_all();
        chk("oor_wr_discard", r_data[0], D1);
        rd(1, BASE - 8, 8'h63); step(); idle_all();
        chk("oor_low_rdata", r_data[1], DBEEF);
        chk("oor_err3", 64'(err_cnt), 64'd3);
        for (int p = 0; p < MP; p++) rd(p, OOR_HI + 32'(8 * p), 8'h64);
        repeat (16382) step();
        chk("sat_pre", 64'(err_cnt), 64'hFFFB);
        step();
        chk("sat_exact", 64'(err_cnt), 64'hFFFF);
        step(); idle_all();
        chk("sat_hold", 64'(err_cnt), 64'hFFFF);
        chk("sat_rdata3", r_data[3], DBEEF);

        // reset with responses pending
        r_ready = '0;
        for (int p = 0; p < MP; p++) rd(p, BASE + 8, 8'h70 + 8'(p));
        step(); idle_all();
        chk("pre_rst_rvalid", 64'(r_valid), 64'hF);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(r_valid), 64'h0);
        chk("mid_rst_err", 64'(err_cnt), 64'h0);
        chk("mid_rst_rdata2", r_data[2], 64'h0);
        step(); step();
        rst_ni = 1'b1;
        r_ready = '1;
        rd(3, BASE + 8, 8'h7F); step(); idle_all();
        chk("post_rst_rvalid3", 64'(r_valid[3]), 64'h1);
        chk("post_rst_rdata3", r_data[3], D1);
        chk("post_rst_rid3", 64'(r_id[3]), 64'h7F);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
